pll_reset_ctrl: RTL and testbench

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

---
 rtl/pll_reset_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl
//   Brings up a PLL and sequences the core reset around it. The PLL is held
//   in reset for a fixed pulse. The controller then waits for lock, retrying
//   with a fresh PLL reset on timeout. Lock must then hold continuously for a
//   settle window before the core is released. While running, a loss of lock
//   restarts the whole sequence, and a soft reset pulses the core reset only.
//
// Parameters
//   RST_CYCLES    PLL reset pulse length in clk cycles        (2..65535)
//   LOCK_TIMEOUT  clk cycles to wait for lock before retrying (2..2^20-1)
//   STABLE_CYCLES continuous-lock settle time before release  (2..65535)
//   SOFT_CYCLES   minimum soft-reset pulse length             (2..65535)
//
// Ports
//   clk         in   free-running PLL reference clock
//   reset       in   asynchronous active-high reset
//   pll_locked  in   PLL lock status, asynchronous to clk
//   soft_reset  in   core-only reset request, level, synchronous to clk
//   pll_rst     out  PLL reset, active high
//   core_reset  out  core reset, active high
//   ready       out  high only while the core runs on a locked clock
//   retry_cnt   out  lock-timeout retries since reset, saturates at 15
//   lock_lost   out  sticky, set when lock drops while running
module pll_reset_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned SOFT_CYCLES   = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic       lock_lost
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT      = 3'd4
  } state_t;

  localparam logic [19:0] RST_LAST    = 20'(RST_CYCLES - 1);
  localparam logic [19:0] LOCK_LAST   = 20'(LOCK_TIMEOUT - 1);
  localparam logic [19:0] STABLE_LAST = 20'(STABLE_CYCLES - 1);
  localparam logic [19:0] SOFT_LAST   = 20'(SOFT_CYCLES - 1);
  localparam logic [19:0] CNT_MAX     = 20'hFFFFF;

  logic        lock_p0;
  logic        lock_s;
  state_t      state;
  state_t      state_nxt;
  logic [19:0] cnt;
  logic [19:0] cnt_nxt;
  logic        retry_inc;
  logic        lost_set;
  logic        pll_rst_nxt;
  logic        core_reset_nxt;
  logic        ready_nxt;

  // ---- stage p0/p1: two-flop lock synchronizer, lock_s feeds every decision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_p0 <= pll_locked;
      lock_s  <= lock_p0;
    end
  end

  // ---- next-state and output decode
  always_comb begin
    state_nxt = state;
    retry_inc = 1'b0;
    lost_set  = 1'b0;
    case (state)
      ST_PLL_RST: begin
        if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = ST_SETTLE;
        end else if (cnt == LOCK_LAST) begin
          state_nxt = ST_PLL_RST;
          retry_inc = 1'b1;
        end
      end
      ST_SETTLE: begin
        // A single dropout restarts the settle window but is not a retry.
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_nxt = ST_PLL_RST;
          lost_set  = 1'b1;
        end else if (soft_reset) begin
          state_nxt = ST_SOFT;
        end
      end
      ST_SOFT: begin
        // Lock loss wins; otherwise a still-held request stretches the pulse.
        if (!lock_s) begin
          state_nxt = ST_PLL_RST;
          lost_set  = 1'b1;
        end else if ((cnt >= SOFT_LAST) && !soft_reset) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_PLL_RST;
      end
    endcase

    // Shared counter restarts on every transition and parks at full scale.
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_nxt = cnt + 20'd1;
    end else begin
      cnt_nxt = cnt;
    end

    // Outputs come from the next state so they switch with the state flop.
    pll_rst_nxt    = (state_nxt == ST_PLL_RST);
    core_reset_nxt = (state_nxt != ST_RUN);
    ready_nxt      = (state_nxt == ST_RUN);
  end

  // ---- state, counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_PLL_RST;
      cnt        <= '0;
      pll_rst    <= 1'b1;
      core_reset <= 1'b1;
      ready      <= 1'b0;
      retry_cnt  <= 4'd0;
      lock_lost  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pll_rst    <= pll_rst_nxt;
      core_reset <= core_reset_nxt;
      ready      <= ready_nxt;
      if (retry_inc && (retry_cnt != 4'hF)) begin
        retry_cnt <= retry_cnt + 4'd1;
      end
      if (lost_set) begin
        lock_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl
//   Scenario tasks for pll_reset_ctrl with small parameters. Expected timings
//   come from arithmetic on the parameters. Inputs are driven 1 ns after a
//   rising edge and outputs are sampled at that same point.
module tb_pll_reset_ctrl;

  localparam int RST_C = 4;
  localparam int TMO_C = 32;
  localparam int STB_C = 8;
  localparam int SFT_C = 4;

  // A retry cycle is the PLL reset pulse plus the full lock wait.
  localparam int RETRY_PERIOD = RST_C + TMO_C;
  // From entering PLL reset with lock present: pulse, one lock-detect cycle, settle.
  localparam int RELOCK_LAT = RST_C + 1 + STB_C;
  // Input change to reaction: two synchronizer flops plus the decision edge.
  localparam int LOSS_LAT = 3;
  // After a one-cycle dropout ends: remaining sync delay plus a full settle.
  localparam int CHATTER_TAIL = STB_C + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       pll_rst;
  logic       core_reset;
  logic       ready;
  logic [3:0] retry_cnt;
  logic       lock_lost;

  int n_cmp = 0;
  int n_bad = 0;

  pll_reset_ctrl #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (TMO_C),
    .STABLE_CYCLES(STB_C),
    .SOFT_CYCLES  (SFT_C)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pll_locked(pll_locked),
    .soft_reset(soft_reset),
    .pll_rst   (pll_rst),
    .core_reset(core_reset),
    .ready     (ready),
    .retry_cnt (retry_cnt),
    .lock_lost (lock_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int exp_soft_len(input int l);
    return (l > SFT_C) ? l : SFT_C;
  endfunction

  function automatic int exp_retry(input int k);
    return (k > 15) ? 15 : k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic lock);
    tick();
    reset = 1'b1;
    pll_locked = lock;
    soft_reset = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    pll_locked = 1'b1;
    reset = 1'b1;
    #2;
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL rst_pll_rst: got %b expected 1", pll_rst); end
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL rst_core_reset: got %b expected 1", core_reset); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b expected 0", ready); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_retry_cnt: got %0d expected 0", retry_cnt); end
    n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL rst_lock_lost: got %b expected 0", lock_lost); end
    repeat (3) tick();
    n_cmp++; if ({pll_rst, core_reset, ready} !== 3'b110) begin n_bad++; $display("FAIL rst_held: got %b expected 110", {pll_rst, core_reset, ready}); end
  endtask

  task automatic test_bringup();
    int n;
    int bad;
    apply_reset(1'b1);
    n = 1;
    for (int g = 0; g < 100; g++) begin
      tick();
      if (!pll_rst) break;
      n++;
    end
    n_cmp++; if (n != RST_C) begin n_bad++; $display("FAIL bringup_pll_rst_len: got %0d expected %0d", n, RST_C); end
    n = 0;
    bad = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
      if (!ready && (pll_rst || !core_reset)) bad++;
    end
    n_cmp++; if (n != 1 + STB_C) begin n_bad++; $display("FAIL bringup_ready_lat: got %0d expected %0d", n, 1 + STB_C); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bringup_pre_run_outputs: got %0d bad cycles expected 0", bad); end
    bad = 0;
    repeat (20) begin
      tick();
      if (!ready || core_reset || pll_rst) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bringup_glitch: got %0d glitches expected 0", bad); end
    n_cmp++; if ({retry_cnt, lock_lost} !== 5'd0) begin n_bad++; $display("FAIL bringup_flags: got retry %0d lost %b expected 0 0", retry_cnt, lock_lost); end
  endtask

  task automatic test_soft();
    int lens[4];
    int high;
    int bad;
    lens[0] = 1;
    lens[1] = 10;
    lens[2] = int'($urandom_range(2, 8));
    lens[3] = int'($urandom_range(1, 12));
    for (int t = 0; t < 4; t++) begin
      repeat ($urandom_range(1, 5)) tick();
      soft_reset = 1'b1;
      high = 0;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
        tick();
        if (i == lens[t] - 1) soft_reset = 1'b0;
        if (!core_reset) break;
        high++;
        if (pll_rst || ready) bad++;
      end
      soft_reset = 1'b0;
      n_cmp++; if (high != exp_soft_len(lens[t])) begin n_bad++; $display("FAIL soft_len_%0d: got %0d expected %0d", lens[t], high, exp_soft_len(lens[t])); end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL soft_pll_rst_%0d: got %0d bad cycles expected 0", lens[t], bad); end
      n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL soft_ready_after_%0d: got %b expected 1", lens[t], ready); end
    end
  endtask

  task automatic test_lock_loss();
    int t;
    int early;
    int n;
    repeat ($urandom_range(1, 10)) tick();
    pll_locked = 1'b0;
    t = 0;
    early = 0;
    while (!pll_rst && t < 20) begin
      tick();
      t++;
      if (!pll_rst && !ready) early++;
    end
    n_cmp++; if (t != LOSS_LAT) begin n_bad++; $display("FAIL loss_latency: got %0d expected %0d", t, LOSS_LAT); end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL loss_early_drop: got %0d expected 0", early); end
    n_cmp++; if ({core_reset, ready, lock_lost} !== 3'b101) begin n_bad++; $display("FAIL loss_outputs: got %b expected 101", {core_reset, ready, lock_lost}); end
    pll_locked = 1'b1;
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    n_cmp++; if (n != RELOCK_LAT) begin n_bad++; $display("FAIL loss_relock_lat: got %0d expected %0d", n, RELOCK_LAT); end
    n_cmp++; if (lock_lost !== 1'b1) begin n_bad++; $display("FAIL loss_sticky: got %b expected 1", lock_lost); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL loss_retry: got %0d expected 0", retry_cnt); end
  endtask

  task automatic test_timeout();
    int nper;
    int k;
    int bad_core;
    logic prev;
    apply_reset(1'b0);
    nper = 17 + int'($urandom_range(0, 2));
    k = 0;
    bad_core = 0;
    prev = 1'b1;
    for (int idx = 1; idx <= nper * RETRY_PERIOD; idx++) begin
      soft_reset = 1'($urandom_range(0, 1));
      tick();
      if (!core_reset || ready) bad_core++;
      if (pll_rst && !prev) begin
        k++;
        n_cmp++; if (idx != k * RETRY_PERIOD) begin n_bad++; $display("FAIL timeout_period_%0d: got cycle %0d expected %0d", k, idx, k * RETRY_PERIOD); end
        n_cmp++; if (int'(retry_cnt) != exp_retry(k)) begin n_bad++; $display("FAIL timeout_retry_%0d: got %0d expected %0d", k, retry_cnt, exp_retry(k)); end
      end
      prev = pll_rst;
    end
    soft_reset = 1'b0;
    n_cmp++; if (k != nper) begin n_bad++; $display("FAIL timeout_pulses: got %0d expected %0d", k, nper); end
    n_cmp++; if (bad_core != 0) begin n_bad++; $display("FAIL timeout_core_reset: got %0d bad cycles expected 0", bad_core); end
    n_cmp++; if (retry_cnt !== 4'd15) begin n_bad++; $display("FAIL timeout_saturate: got %0d expected 15", retry_cnt); end
  endtask

  task automatic test_chatter();
    int n;
    int bad;
    apply_reset(1'b0);
    n = 0;
    while (pll_rst && n < 200) begin tick(); n++; end
    while (!pll_rst && n < 200) begin tick(); n++; end
    n_cmp++; if (n != RETRY_PERIOD) begin n_bad++; $display("FAIL chatter_first_retry: got %0d expected %0d", n, RETRY_PERIOD); end
    n_cmp++; if (retry_cnt !== 4'd1) begin n_bad++; $display("FAIL chatter_retry_pre: got %0d expected 1", retry_cnt); end
    pll_locked = 1'b1;
    repeat (3 + $urandom_range(0, 6)) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    n = 0;
    bad = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
      if (pll_rst) bad++;
    end
    n_cmp++; if (n != CHATTER_TAIL) begin n_bad++; $display("FAIL chatter_ready_lat: got %0d expected %0d", n, CHATTER_TAIL); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL chatter_pll_rst: got %0d cycles expected 0", bad); end
    n_cmp++; if (retry_cnt !== 4'd1) begin n_bad++; $display("FAIL chatter_retry_post: got %0d expected 1", retry_cnt); end
    n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL chatter_lock_lost: got %b expected 0", lock_lost); end
  endtask

  task automatic test_soft_lock_loss();
    int t;
    int n;
    tick();
    soft_reset = 1'b1;
    repeat (SFT_C + 2) tick();
    n_cmp++; if ({pll_rst, core_reset, ready} !== 3'b010) begin n_bad++; $display("FAIL softloss_in_soft: got %b expected 010", {pll_rst, core_reset, ready}); end
    pll_locked = 1'b0;
    t = 0;
    while (!pll_rst && t < 20) begin tick(); t++; end
    n_cmp++; if (t != LOSS_LAT) begin n_bad++; $display("FAIL softloss_latency: got %0d expected %0d", t, LOSS_LAT); end
    n_cmp++; if (lock_lost !== 1'b1) begin n_bad++; $display("FAIL softloss_lock_lost: got %b expected 1", lock_lost); end
    soft_reset = 1'b0;
    pll_locked = 1'b1;
    n = 0;
    while (!ready && n < 200) begin tick(); n++; end
    n_cmp++; if (n != RELOCK_LAT) begin n_bad++; $display("FAIL softloss_relock: got %0d expected %0d", n, RELOCK_LAT); end
    n_cmp++; if (retry_cnt !== 4'd1) begin n_bad++; $display("FAIL softloss_retry: got %0d expected 1", retry_cnt); end
  endtask

  task automatic test_async_reset();
    int n;
    repeat ($urandom_range(2, 6)) tick();
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if ({pll_rst, core_reset, ready} !== 3'b110) begin n_bad++; $display("FAIL async_outputs: got %b expected 110", {pll_rst, core_reset, ready}); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL async_retry: got %0d expected 0", retry_cnt); end
    n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL async_lock_lost: got %b expected 0", lock_lost); end
    tick();
    reset = 1'b0;
    n = 1;
    for (int g = 0; g < 100; g++) begin
      tick();
      if (!pll_rst) break;
      n++;
    end
    n_cmp++; if (n != RST_C) begin n_bad++; $display("FAIL async_restart_len: got %0d expected %0d", n, RST_C); end
    n = 0;
    while (!ready && n < 200) begin tick(); n++; end
    n_cmp++; if (n != 1 + STB_C) begin n_bad++; $display("FAIL async_ready_lat: got %0d expected %0d", n, 1 + STB_C); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_soft();
    test_lock_loss();
    test_timeout();
    test_chatter();
    test_soft_lock_loss();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
